cell_gauss_filter: RTL
======================

// Module: cell_gauss_filter
// PURPOSE
//  Consumes the 3x3 RGB333 window (A..I, row-major, A=top-left, E=centre) from the line-buffer window stage.
//  Produces one 1-2-1 Gaussian-smoothed pixel per window advance; frame-border pixels pass through unfiltered.
//  Sits between the window generator and the video output encoder.
//  Fully pipelined; accepts one window per clock.
// PARAMETERS
//  H_ACTIVE  320  active pixels per line (window centres per line)
//  V_ACTIVE  240  active lines per frame
// PORTS
//  iClk27   in   1  system clock, 27 MHz; sole clock
//  iRst     in   1  synchronous, active-high reset
//  iEn      in   1  window-advance strobe; same qualifier that shifts the window stage
//  iSof     in   1  first window of frame; sampled only when iEn=1
//  iSol     in   1  first window of line; sampled only when iEn=1
//  iA..iI   in   9  window pixels; [8:6]=R, [5:3]=G, [2:0]=B
//  iMode    in   1  0=blur, 1=sharpen (present only with CELL_GAUSS_SHARPEN_EN)
//  oRGB     out  9  filtered pixel
//  oValid   out  1  oRGB/oSof/oSol valid this clock
//  oSof     out  1  iSof delayed with its pixel
//  oSol     out  1  iSol delayed with its pixel
// BEHAVIOUR
//  Reset: oRGB=0, oValid=0, oSof=0, oSol=0; x=0, y=0; all pipeline valids cleared. Takes effect the next edge.
//  Reset mid-frame: in-flight pixels are discarded, never emitted.
//  Latency: exactly 3 clocks from iEn=1 to oValid=1. oValid is iEn delayed 3; no stall, no backpressure.
//  Outputs hold their last value while oValid=0.
//  Position counters (advance only when iEn=1):
//   iSof=1 -> x=0, y=0 (overrides iSol).
//   iSol=1 (iSof=0) -> x=0, y=min(y+1, V_ACTIVE-1).
//   else -> x=min(x+1, H_ACTIVE-1).
//   Both saturate; they never wrap.
//  Border: x==0 | x==H_ACTIVE-1 | y==0 | y==V_ACTIVE-1 -> oRGB = iE (bypass), same 3-clock latency.
//  Per-channel arithmetic (unsigned):
//   S = (A+C+G+I) + 2*(B+D+F+H) + 4*E; 7 bits, max 112.
//   blur = (S + 8) >> 4; round-half-up; result fits in 3 bits, so no clamp is needed.
//  Pipe stage 1: corner sum, edge sum, 4*E, border flag, flags, valid.
//  Pipe stage 2: total + 8.
//  Pipe stage 3: shift, bypass/mode mux, output registers.
// CONFIGURATION
//  CELL_GAUSS_SHARPEN_EN defined:
//   - iMode port exists.
//   - iMode=1 -> channel = clamp(2*E - blur, 0, 7), computed signed in 5 bits.
//   - iMode is registered with its pixel; no glitch on mid-line change.
//   - Border bypass still applies.
//  Not defined: no iMode port; output is always blur (or bypass at the border).
// STRUCTURE
//  cell_filter_pkg:
//   - typedef rgb9_t; localparams R_LSB=6, G_LSB=3, B_LSB=0, CH_W=3.
//   - Kernel weights W_CORNER=1, W_EDGE=2, W_CENTRE=4; SUM_W=7; ROUND=8; SHIFT=4.
//  Sub-module cell_gauss_channel: one 3-bit channel through stages 1-2 (adder tree).
//   Instantiated 3x; the top holds counters, flag delay line, stage 3.
// TESTING
//  1 Interior, all inputs 9'o777, iEn every clock -> oRGB=9'o777 three clocks later.
//    oValid continuous.
//  2 Interior impulse: iE=9'o700, others 0 -> R=(28+8)>>4=2, so oRGB=9'o200.
//  3 Border: iSol=1, iE=9'o123, others 9'o777 -> oRGB=9'o123, oSol=1 with it.
//  4 iEn every 4th clock -> oValid follows the same pattern shifted 3 clocks.
//    Counters step only on iEn; x saturates at H_ACTIVE-1 with no iSol.
//  5 iRst pulsed while 2 pixels in flight -> next clock oValid=0.
//    Those pixels are never output; the next frame after iSof is correct.
//  6 (CELL_GAUSS_SHARPEN_EN) iMode=1, interior, iE=9'o444, others 0.
//    Blur per channel=1, so oRGB=clamp(8-1)=9'o777.
//    With iMode=0 -> 9'o111.

Source files
------------

// File: rtl/cell_filter_pkg.sv
// Shared types and kernel constants for the 3x3 RGB333 Gaussian filter.
// Optional sharpen helper is compiled only with CELL_GAUSS_SHARPEN_EN.
package cell_filter_pkg;

    localparam int unsigned CH_W  = 3;
    localparam int unsigned R_LSB = 6;
    localparam int unsigned G_LSB = 3;
    localparam int unsigned B_LSB = 0;

    typedef logic [3*CH_W-1:0] rgb9_t;

    localparam int unsigned W_CORNER = 1;
    localparam int unsigned W_EDGE   = 2;
    localparam int unsigned W_CENTRE = 4;
    localparam int unsigned SUM_W    = 7;
    localparam int unsigned ROUND    = 8;
    localparam int unsigned SHIFT    = 4;

`ifdef CELL_GAUSS_SHARPEN_EN
    // 2*E - blur spans -7..14, so 5 signed bits hold it before clamping to 0..7.
    function automatic logic [CH_W-1:0] sharpen_ch(input logic [CH_W-1:0] e,
                                                  input logic [CH_W-1:0] blur);
        logic signed [CH_W+1:0] diff;
        diff = $signed({1'b0, e, 1'b0}) - $signed({2'b00, blur});
        if (diff < 0) begin
            return '0;
        end else if (diff > 7) begin
            return '1;
        end else begin
            return diff[CH_W-1:0];
        end
    endfunction
`endif

endpackage

// File: rtl/cell_gauss_channel.sv
// One colour channel of the 1-2-1 kernel: stage 1 partial sums, stage 2 rounded total.
// Emits the rounded total already shifted down to the channel width.
module cell_gauss_channel
    import cell_filter_pkg::*;
(
    input  logic            clk_i,
    input  logic [CH_W-1:0] a_i,
    input  logic [CH_W-1:0] b_i,
    input  logic [CH_W-1:0] c_i,
    input  logic [CH_W-1:0] d_i,
    input  logic [CH_W-1:0] e_i,
    input  logic [CH_W-1:0] f_i,
    input  logic [CH_W-1:0] g_i,
    input  logic [CH_W-1:0] h_i,
    input  logic [CH_W-1:0] i_i,
    output logic [CH_W-1:0] blur_o
);

    localparam int unsigned PW = CH_W + 2;

    logic [PW-1:0]    corner_d, corner_q;
    logic [PW-1:0]    edg_d, edg_q;
    logic [PW-1:0]    centre_d, centre_q;
    logic [SUM_W-1:0] sum_d, sum_q;

    always_comb begin
        corner_d = PW'(a_i) + PW'(c_i) + PW'(g_i) + PW'(i_i);
        edg_d    = PW'(b_i) + PW'(d_i) + PW'(f_i) + PW'(h_i);
        centre_d = PW'(e_i) * PW'(W_CENTRE);
        sum_d    = SUM_W'(corner_q) * SUM_W'(W_CORNER) + SUM_W'(edg_q) * SUM_W'(W_EDGE)
                 + SUM_W'(centre_q) + SUM_W'(ROUND);
    end

    // Datapath only; validity travels alongside in the top.
    always_ff @(posedge clk_i) begin
        corner_q <= corner_d;
        edg_q    <= edg_d;
        centre_q <= centre_d;
        sum_q    <= sum_d;
    end

    assign blur_o = CH_W'(sum_q >> SHIFT);

endmodule

// File: rtl/cell_gauss_filter.sv
// 3x3 RGB333 Gaussian smoother, 3-clock latency, border pixels bypassed.
// Define CELL_GAUSS_SHARPEN_EN to add the iMode port and the sharpen path.
module cell_gauss_filter
    import cell_filter_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240
) (
    input  logic  iClk27,
    input  logic  iRst,
    input  logic  iEn,
    input  logic  iSof,
    input  logic  iSol,
    input  rgb9_t iA,
    input  rgb9_t iB,
    input  rgb9_t iC,
    input  rgb9_t iD,
    input  rgb9_t iE,
    input  rgb9_t iF,
    input  rgb9_t iG,
    input  rgb9_t iH,
    input  rgb9_t iI,
`ifdef CELL_GAUSS_SHARPEN_EN
    input  logic  iMode,
`endif
    output rgb9_t oRGB,
    output logic  oValid,
    output logic  oSof,
    output logic  oSol
);

    localparam int unsigned XW = $clog2(H_ACTIVE);
    localparam int unsigned YW = $clog2(V_ACTIVE);
    localparam logic [XW-1:0] XMAX = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] YMAX = YW'(V_ACTIVE - 1);

    logic [XW-1:0] x_d, x_q;
    logic [YW-1:0] y_d, y_q;
    logic          border_d;

    // The position computed here belongs to the window presented this clock.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (iSof) begin
            x_d = '0;
            y_d = '0;
        end else if (iSol) begin
            x_d = '0;
            y_d = (y_q == YMAX) ? YMAX : y_q + YW'(1);
        end else begin
            x_d = (x_q == XMAX) ? XMAX : x_q + XW'(1);
        end
        border_d = (x_d == '0) || (x_d == XMAX) || (y_d == '0) || (y_d == YMAX);
    end

    logic  v1_q, sof1_q, sol1_q, border1_q;
    logic  v2_q, sof2_q, sol2_q, border2_q;
    rgb9_t e1_q, e2_q;
`ifdef CELL_GAUSS_SHARPEN_EN
    logic  mode1_q, mode2_q;
`endif

    always_ff @(posedge iClk27) begin
        if (iRst) begin
            x_q  <= '0;
            y_q  <= '0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            if (iEn) begin
                x_q <= x_d;
                y_q <= y_d;
            end
            v1_q <= iEn;
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge iClk27) begin
        sof1_q    <= iSof;
        sol1_q    <= iSol;
        border1_q <= border_d;
        e1_q      <= iE;
        sof2_q    <= sof1_q;
        sol2_q    <= sol1_q;
        border2_q <= border1_q;
        e2_q      <= e1_q;
`ifdef CELL_GAUSS_SHARPEN_EN
        mode1_q   <= iMode;
        mode2_q   <= mode1_q;
`endif
    end

    logic [CH_W-1:0] filt_ch [3];
    rgb9_t           filt;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        localparam int unsigned Lsb = (c == 0) ? B_LSB : (c == 1) ? G_LSB : R_LSB;
        logic [CH_W-1:0] blur;

        cell_gauss_channel u_chan (
            .clk_i  (iClk27),
            .a_i    (iA[Lsb +: CH_W]),
            .b_i    (iB[Lsb +: CH_W]),
            .c_i    (iC[Lsb +: CH_W]),
            .d_i    (iD[Lsb +: CH_W]),
            .e_i    (iE[Lsb +: CH_W]),
            .f_i    (iF[Lsb +: CH_W]),
            .g_i    (iG[Lsb +: CH_W]),
            .h_i    (iH[Lsb +: CH_W]),
            .i_i    (iI[Lsb +: CH_W]),
            .blur_o (blur)
        );

`ifdef CELL_GAUSS_SHARPEN_EN
        assign filt_ch[c] = mode2_q ? sharpen_ch(e2_q[Lsb +: CH_W], blur) : blur;
`else
        assign filt_ch[c] = blur;
`endif
    end

    assign filt = {filt_ch[2], filt_ch[1], filt_ch[0]};

    rgb9_t rgb_q;
    logic  valid_q, sof_q, sol_q;

    // Outputs only move on a valid pixel so they hold through gaps.
    always_ff @(posedge iClk27) begin
        if (iRst) begin
            rgb_q   <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            sol_q   <= 1'b0;
        end else begin
            valid_q <= v2_q;
            if (v2_q) begin
                rgb_q <= border2_q ? e2_q : filt;
                sof_q <= sof2_q;
                sol_q <= sol2_q;
            end
        end
    end

    assign oRGB   = rgb_q;
    assign oValid = valid_q;
    assign oSof   = sof_q;
    assign oSol   = sol_q;

endmodule
